// File: rtl/counter_nbit_prescaled.sv
// counter_nbit_prescaled
//   Up/down modulo-N counter with a clock-enable prescaler and synchronous load.
//   Every PRESCALE enabled clocks the counter takes one step in the direction
//   selected by `up`. Moving past MODULUS-1 going up, or past 0 going down,
//   wraps the count and raises a terminal-count pulse.
//
// Parameters
//   WIDTH    count width, 2..16
//   MODULUS  count sequence length, 2..2**WIDTH
//   PRESCALE enabled clocks per count step, 1..65536
//
// Build option
//   COUNTER_SATURATE_EN  when defined, a step at a bound holds the count at
//                        that bound instead of wrapping. tick and tc still
//                        pulse on each attempted step at the bound.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   en       in   count enable; counter and prescaler hold while low
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   synchronous load; wins over en
//   load_val in   load value, clamped to MODULUS-1
//   counter  out  registered count, always < MODULUS
//   tick     out  one-cycle pulse, aligned with each new stepped value
//   tc       out  one-cycle terminal-count pulse, aligned with tick
module counter_nbit_prescaled #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             tc
);

  // With PRESCALE=1 the prescaler is a single bit that never leaves 0, so
  // every enabled clock lands on the last phase and steps.
  localparam int               PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS = 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [PSW-1:0]   ps, ps_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tick_nxt, tc_nxt;
  logic             ps_wrap;

  assign ps_wrap = (ps == PS_LAST);

  always_comb begin
    ps_nxt   = ps;
    cnt_nxt  = counter;
    tick_nxt = 1'b0;
    tc_nxt   = 1'b0;
    if (load) begin
      // A load restarts the step phase so the next step is a full period out.
      ps_nxt = '0;
      if ({1'b0, load_val} >= MOD_EXT) cnt_nxt = CNT_MAX;
      else                             cnt_nxt = load_val;
    end else if (en) begin
      if (ps_wrap) begin
        ps_nxt   = '0;
        tick_nxt = 1'b1;
        if (up) begin
          if (counter == CNT_MAX) begin
            tc_nxt  = 1'b1;
            cnt_nxt = SAT ? CNT_MAX : '0;
          end else begin
            cnt_nxt = counter + WIDTH'(1);
          end
        end else begin
          if (counter == '0) begin
            tc_nxt  = 1'b1;
            cnt_nxt = SAT ? '0 : CNT_MAX;
          end else begin
            cnt_nxt = counter - WIDTH'(1);
          end
        end
      end else begin
        ps_nxt = ps + PSW'(1);
      end
    end
  end

  // tick/tc are registered alongside the count so they line up with the
  // value they describe; they drop to 0 on any non-step cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps      <= '0;
      counter <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else begin
      ps      <= ps_nxt;
      counter <= cnt_nxt;
      tick    <= tick_nxt;
      tc      <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_counter_nbit_prescaled.sv
module tb_counter_nbit_prescaled;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_val = 4'h0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tick_a, tick_b, tick_c, tc_a, tc_b, tc_c;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         sel;
    logic [5:0] v;   // {counter, tick, tc}
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       en, up, ld;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       tk, tc;
  } row_t;

  always #5 clk = ~clk;

  // A: 16-state, every enabled clock steps
  counter_nbit_prescaled #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(cnt_a), .tick(tick_a), .tc(tc_a));
  // B: decade counter, step every 3 enabled clocks
  counter_nbit_prescaled #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(cnt_b), .tick(tick_b), .tc(tc_b));
  // C: 16-state, step every 2 enabled clocks
  counter_nbit_prescaled #(.WIDTH(4), .MODULUS(16), .PRESCALE(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(cnt_c), .tick(tick_c), .tc(tc_c));

  function automatic logic [5:0] obs(int sel);
    case (sel)
      0:       return {cnt_a, tick_a, tc_a};
      1:       return {cnt_b, tick_b, tc_b};
      default: return {cnt_c, tick_c, tc_c};
    endcase
  endfunction

  function automatic row_t mk(int en_i, int up_i, int ld_i, int lv_i,
                              int c_i, int tk_i, int tc_i);
    row_t r;
    r.en  = en_i[0];
    r.up  = up_i[0];
    r.ld  = ld_i[0];
    r.lv  = lv_i[3:0];
    r.cnt = c_i[3:0];
    r.tk  = tk_i[0];
    r.tc  = tc_i[0];
    return r;
  endfunction

  // Leaves rst released at a falling edge with all inputs idle.
  task automatic apply_reset();
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'h0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    sb_t  e;
    logic [5:0] got;
    #2 rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      e = '{sel: s, v: 6'h00};
      got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL reset_async dut%0d: got cnt=%0d tick=%b tc=%b want 0/0/0",
                 s, got[5:2], got[1], got[0]);
      end
    end
    // Clocks with en and load active must not disturb a held reset.
    en = 1'b1; load = 1'b1; load_val = 4'h5;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) sb.push_back('{sel: s, v: 6'h00});
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        e = sb.pop_front(); got = obs(e.sel); n_cmp++;
        if (got !== e.v) begin
          n_err++;
          $display("FAIL reset_hold dut%0d edge%0d: got cnt=%0d tick=%b tc=%b want 0/0/0",
                   e.sel, k, got[5:2], got[1], got[0]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0;
  endtask

  // Shared row runner body is written out in each test so each owns its checks.
  task automatic test_wrap();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    for (int i = 1; i <= 17; i++) rows.push_back(mk(1, 1, 0, 0, i % 16, 1, (i == 16) ? 1 : 0));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 0, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL wrap_up row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_down_prescale();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    int   steps;
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      steps = k / 3;
      rows.push_back(mk(1, 0, 0, 0, (steps == 0) ? 0 : 10 - steps,
                        (k % 3 == 0) ? 1 : 0, (k == 3) ? 1 : 0));
    end
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL down_prescale row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_load();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(1, 0, 0, 0,   0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,   0, 0, 0));
    // Load lands on the edge that would otherwise step: no tick, clamp to 9.
    rows.push_back(mk(1, 0, 1, 12,  9, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,   9, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,   9, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,   8, 1, 0));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL load_clamp row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(0, 0, 1, 12, 9, 0, 0));
    rows.push_back(mk(0, 0, 1, 3,  3, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,  3, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,  3, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,  2, 1, 0));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL back_to_back row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(0, 1, 1, 5, 5, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 6, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 6, 0, 0));   // prescaler now mid-phase
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL pre_reset row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
    // Drop reset between edges; a load presented during reset is discarded.
    #2 rst = 1'b0;
    load = 1'b1; load_val = 4'h7;
    sb.push_back('{sel: 1, v: 6'h00});
    #1;
    e = sb.pop_front(); got = obs(e.sel); n_cmp++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL reset_midcount: got cnt=%0d tick=%b tc=%b want 0/0/0", got[5:2], got[1], got[0]);
    end
    sb.push_back('{sel: 1, v: 6'h00});
    @(posedge clk); #1;
    e = sb.pop_front(); got = obs(e.sel); n_cmp++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL reset_midload: got cnt=%0d tick=%b tc=%b want 0/0/0", got[5:2], got[1], got[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    rows.delete();
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 1, 0));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL post_reset row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_en_gaps();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 1, 0));
    rows.push_back(mk(0, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 2, 1, 0));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 2, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL en_gaps row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_dir_toggle();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));   // mid-phase toggle has no effect
    rows.push_back(mk(1, 1, 0, 0, 1, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 0));   // 1 -> 0 is not a bound crossing
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 9, 1, 1));
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 1, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL dir_toggle row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_bound();
    row_t rows[$];
    sb_t  e;
    logic [5:0] got;
    apply_reset();
    rows.push_back(mk(0, 1, 1, 14, 14, 0, 0));
`ifdef COUNTER_SATURATE_EN
    rows.push_back(mk(1, 1, 0, 0, 15, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 15, 1, 1));
    rows.push_back(mk(1, 1, 0, 0, 15, 1, 1));
    rows.push_back(mk(0, 0, 1, 1,  1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,  0, 1, 0));
    rows.push_back(mk(1, 0, 0, 0,  0, 1, 1));
    rows.push_back(mk(1, 0, 0, 0,  0, 1, 1));
`else
    rows.push_back(mk(1, 1, 0, 0, 15, 1, 0));
    rows.push_back(mk(1, 1, 0, 0,  0, 1, 1));
    rows.push_back(mk(1, 1, 0, 0,  1, 1, 0));
    rows.push_back(mk(0, 0, 1, 1,  1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0,  0, 1, 0));
    rows.push_back(mk(1, 0, 0, 0, 15, 1, 1));
    rows.push_back(mk(1, 0, 0, 0, 14, 1, 0));
`endif
    rows.push_back(mk(0, 1, 1, 15, 15, 0, 0));  // top code loads unclamped
    rows.push_back(mk(0, 1, 0, 0,  15, 0, 0));  // disabled: hold, no pulses
    foreach (rows[i]) begin
      en = rows[i].en; up = rows[i].up; load = rows[i].ld; load_val = rows[i].lv;
      sb.push_back('{sel: 0, v: {rows[i].cnt, rows[i].tk, rows[i].tc}});
      @(posedge clk); #1;
      e = sb.pop_front(); got = obs(e.sel); n_cmp++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL bound row%0d: got cnt=%0d tick=%b tc=%b want cnt=%0d tick=%b tc=%b",
                 i, got[5:2], got[1], got[0], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap();
    test_down_prescale();
    test_load();
    test_back_to_back();
    test_async_reset();
    test_en_gaps();
    test_dir_toggle();
    test_bound();
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
